// File: rtl/tpu_ctrl_if.sv
// Host bus between the host and tpu_ctrl: one word access per cycle,
// with read data returned one cycle after the request.
interface tpu_ctrl_if #(
    parameter int ADDRW = 16,
    parameter int DATAW = 64
);
    logic             req;
    logic             r_w;
    logic [ADDRW-1:0] addr;
    logic [DATAW-1:0] dataIn;
    logic [DATAW-1:0] dataOut;
    logic             rd_valid;

    modport master (
        output req, r_w, addr, dataIn,
        input  dataOut, rd_valid
    );

    modport slave (
        input  req, r_w, addr, dataIn,
        output dataOut, rd_valid
    );
endinterface

// File: rtl/tpu_ctrl.sv
// Host-side sequencer for the matrix datapath. It decodes host accesses into
// memA/memB/array strobes and runs the array for 3*DIM-2 cycles on start.
module tpu_ctrl #(
    parameter int BITS_AB = 8,
    parameter int BITS_C  = 16,
    parameter int DIM     = 8,
    parameter int ADDRW   = 16,
    parameter int DATAW   = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    tpu_ctrl_if.slave                host,
    output logic                     a_en,
    output logic                     a_wr_en,
    output logic [$clog2(DIM)-1:0]   a_row,
    output logic [DIM*BITS_AB-1:0]   a_in,
    output logic                     b_en,
    output logic [DATAW-1:0]         b_in,
    output logic                     sa_en,
    output logic                     sa_wr_en,
    output logic [$clog2(DIM)-1:0]   c_row,
    output logic [DIM*BITS_C-1:0]    c_in,
    input  logic [DIM*BITS_C-1:0]    c_out
);
    localparam int RW = $clog2(DIM);
    localparam int CW = $clog2(3*DIM-1);
    localparam logic [CW-1:0] LAST = CW'(3*DIM-2);
    localparam logic [7:0] REG_A = 8'h01, REG_B = 8'h02, REG_C = 8'h03, REG_CTRL = 8'h04;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            done, err, busy;
    logic [DATAW-1:0] hold;
    logic [DATAW-1:0] dout_p1;
    logic            vld_p1;

    logic [7:0]      region;
    logic [RW-1:0]   ra, rc;
    logic            h, wr, rd, in_run;
    logic [DATAW-1:0] rd_data;
    logic            unused_addr;

    assign region = host.addr[15:8];
    assign ra     = host.addr[RW-1:0];
    assign rc     = host.addr[RW:1];
    assign h      = host.addr[0];
    assign wr     = host.req && host.r_w && !rst;
    assign rd     = host.req && !host.r_w && !rst;
    assign busy   = (state == RUN);
    assign in_run = busy && !rst;
    assign unused_addr = ^host.addr[7:RW+1];

    // Datapath strobes: zero-latency from the request; RUN overrides host writes
    always_comb begin
        a_en     = 1'b0;
        a_wr_en  = 1'b0;
        a_row    = '0;
        a_in     = '0;
        b_en     = 1'b0;
        b_in     = '0;
        sa_en    = 1'b0;
        sa_wr_en = 1'b0;
        c_row    = '0;
        c_in     = '0;
        if (in_run) begin
            a_en  = 1'b1;
            b_en  = 1'b1;
            sa_en = 1'b1;
        end else if (wr) begin
            case (region)
                REG_A: begin
                    a_en    = 1'b1;
                    a_wr_en = 1'b1;
                    a_row   = ra;
                    a_in    = host.dataIn;
                end
                REG_B: begin
                    b_en = 1'b1;
                    b_in = host.dataIn;
                end
                REG_C: if (h) begin
                    sa_wr_en = 1'b1;
                    c_row    = rc;
                    c_in     = {host.dataIn, hold};
                end
                default: ;
            endcase
        end
        if (rd && region == REG_C)
            c_row = rc;
    end

    always_comb begin
        rd_data = '0;
        case (region)
            REG_C:    rd_data = h ? c_out[2*DATAW-1:DATAW] : c_out[DATAW-1:0];
            REG_CTRL: rd_data = DATAW'({err, done, busy});
            default:  ;
        endcase
    end

    // Stage p1: registered read response and sequencer state
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            hold    <= '0;
            dout_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= rd;
            if (rd)
                dout_p1 <= rd_data;
            case (state)
                IDLE: begin
                    if (wr && region == REG_C && !h)
                        hold <= host.dataIn;
                    if (wr && region == REG_CTRL) begin
                        if (host.dataIn[1]) begin
                            done <= 1'b0;
                            err  <= 1'b0;
                        end
                        if (host.dataIn[0]) begin
                            done  <= 1'b0;
                            state <= RUN;
                            cnt   <= CW'(1);
                        end
                    end
                end
                RUN: begin
                    if (wr)
                        err <= 1'b1;
                    if (cnt == LAST) begin
                        state <= IDLE;
                        done  <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign host.dataOut  = dout_p1;
    assign host.rd_valid = vld_p1;
endmodule

// File: tb/tb_tpu_ctrl.sv
// Scoreboard bench for tpu_ctrl with a behavioural stand-in for memA/memB/array.
module tb_tpu_ctrl;
    localparam int BITS_AB = 8, BITS_C = 16, DIM = 8, ADDRW = 16, DATAW = 64, RW = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tpu_ctrl_if #(.ADDRW(ADDRW), .DATAW(DATAW)) bus();

    logic                  a_en, a_wr_en, b_en, sa_en, sa_wr_en;
    logic [RW-1:0]         a_row, c_row;
    logic [DATAW-1:0]      a_in, b_in;
    logic [2*DATAW-1:0]    c_in, c_out;

    tpu_ctrl #(.BITS_AB(BITS_AB), .BITS_C(BITS_C), .DIM(DIM), .ADDRW(ADDRW), .DATAW(DATAW)) dut (
        .clk(clk), .rst(rst), .host(bus),
        .a_en(a_en), .a_wr_en(a_wr_en), .a_row(a_row), .a_in(a_in),
        .b_en(b_en), .b_in(b_in),
        .sa_en(sa_en), .sa_wr_en(sa_wr_en), .c_row(c_row), .c_in(c_in), .c_out(c_out)
    );

    int tests = 0;
    int fails = 0;
    logic [DATAW-1:0] expq[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural datapath: captures A rows, B rows in write order, and
    // applies C += A*B once sa_en has been held for 3*DIM-2 cycles.
    logic [BITS_AB-1:0] am[DIM][DIM];
    logic [BITS_AB-1:0] bm[DIM][DIM];
    logic [BITS_C-1:0]  cm[DIM][DIM];
    int bcount, runcnt, acc, sa_cycles;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DIM; i++)
                for (int j = 0; j < DIM; j++)
                    cm[i][j] <= '0;
            bcount <= 0;
            runcnt <= 0;
        end else begin
            if (a_wr_en)
                for (int j = 0; j < DIM; j++) am[a_row][j] <= a_in[j*BITS_AB +: BITS_AB];
            if (b_en && !sa_en) begin
                for (int j = 0; j < DIM; j++) bm[bcount % DIM][j] <= b_in[j*BITS_AB +: BITS_AB];
                bcount <= bcount + 1;
            end
            if (sa_wr_en)
                for (int j = 0; j < DIM; j++) cm[c_row][j] <= c_in[j*BITS_C +: BITS_C];
            if (sa_en) begin
                if (runcnt == 3*DIM-3) begin
                    for (int i = 0; i < DIM; i++)
                        for (int j = 0; j < DIM; j++) begin
                            acc = 0;
                            for (int k = 0; k < DIM; k++) acc += int'(am[i][k]) * int'(bm[k][j]);
                            cm[i][j] <= cm[i][j] + acc[BITS_C-1:0];
                        end
                    runcnt <= 0;
                end else begin
                    runcnt <= runcnt + 1;
                end
            end else begin
                runcnt <= 0;
            end
        end
    end

    always @(posedge clk) if (sa_en) sa_cycles++;

    always_comb begin
        c_out = '0;
        for (int j = 0; j < DIM; j++) c_out[j*BITS_C +: BITS_C] = cm[c_row][j];
    end

    // Monitor: every read response pops the oldest expectation
    always @(negedge clk) begin
        if (bus.rd_valid) begin
            if (expq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rd_unexpected: got rd_valid=1 data %h required no response", bus.dataOut);
            end else begin
                check("rd_data", bus.dataOut, expq.pop_front());
            end
        end
    end

    task automatic wr(input logic [15:0] a, input logic [63:0] d);
        @(negedge clk);
        bus.req = 1'b1; bus.r_w = 1'b1; bus.addr = a; bus.dataIn = d;
        #1;
    endtask

    task automatic rd(input logic [15:0] a, input logic [63:0] e);
        @(negedge clk);
        bus.req = 1'b1; bus.r_w = 1'b0; bus.addr = a; bus.dataIn = '0;
        expq.push_back(e);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.req = 1'b0; bus.r_w = 1'b0; bus.addr = '0; bus.dataIn = '0;
        end
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.req = 1'b1; bus.r_w = 1'b1; bus.addr = 16'h0103; bus.dataIn = '1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_a_wr_en", a_wr_en, 0);
        check("rst_a_en", a_en, 0);
        check("rst_a_in", a_in, 0);
        check("rst_a_row", a_row, 0);
        check("rst_sa_en", sa_en, 0);
        check("rst_dataOut", bus.dataOut, 0);
        check("rst_rd_valid", bus.rd_valid, 0);
        bus.req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        rd(16'h0400, 64'h0);

        wr(16'h0103, 64'h0102030405060708);
        check("a_wr_en", a_wr_en, 1);
        check("a_en", a_en, 1);
        check("a_row", a_row, 3);
        check("a_in", a_in, 64'h0102030405060708);
        idle(1);
        check("a_wr_en_off", a_wr_en, 0);
        check("a_in_off", a_in, 0);

        wr(16'h0304, 64'hAAAAAAAAAAAAAAAA);
        check("c_hold_no_strobe", sa_wr_en, 0);
        wr(16'h0305, 64'h5555555555555555);
        check("c_sa_wr_en", sa_wr_en, 1);
        check("c_row", c_row, 2);
        check("c_in", c_in, {64'h5555555555555555, 64'hAAAAAAAAAAAAAAAA});
        rd(16'h0304, 64'hAAAAAAAAAAAAAAAA);
        rd(16'h0305, 64'h5555555555555555);

        wr(16'h0207, 64'h1122334455667788);
        check("b_en", b_en, 1);
        check("b_in", b_in, 64'h1122334455667788);
        rd(16'h0200, 64'h0);
        rd(16'h0103, 64'h0);
        wr(16'h0500, 64'hFFFF);
        check("other_no_strobe", {a_en, b_en, sa_en, sa_wr_en}, 0);
        rd(16'h0500, 64'h0);
        idle(2);

        // Clean run: exactly 22 sa_en cycles, status busy then done
        sa_cycles = 0;
        wr(16'h0400, 64'h1);
        check("start_cycle_sa_en", sa_en, 0);
        idle(1);
        check("run_sa_en", sa_en, 1);
        check("run_b_in", b_in, 0);
        rd(16'h0400, 64'h1);
        idle(30);
        check("sa_en_cycles", sa_cycles, 3*DIM-2);
        rd(16'h0400, 64'h2);

        // Restart with done set, write during run sets err
        wr(16'h0400, 64'h1);
        idle(2);
        wr(16'h0101, 64'hDEAD);
        check("run_write_dropped", a_wr_en, 0);
        idle(30);
        rd(16'h0400, 64'h6);
        wr(16'h0400, 64'h3);
        idle(1);
        rd(16'h0400, 64'h1);
        idle(30);
        rd(16'h0400, 64'h2);
        wr(16'h0400, 64'h2);
        rd(16'h0400, 64'h0);

        // Reset in the middle of a run
        wr(16'h0400, 64'h1);
        idle(10);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_sa_en", sa_en, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_sa_en", sa_en, 0);
        rd(16'h0400, 64'h0);
        wr(16'h0303, 64'h77);
        check("hold_after_rst", c_in, {64'h77, 64'h0});
        check("hold_c_row", c_row, 1);

        // Identity A times identity B
        idle(1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < DIM; i++) wr(16'(16'h0100 + i), 64'h1 << (8*i));
        for (int i = 0; i < DIM; i++) wr(16'h0200, 64'h1 << (8*i));
        wr(16'h0400, 64'h1);
        idle(30);
        for (int r = 0; r < DIM; r++) begin
            rd(16'(16'h0300 + 2*r), (r < 4) ? (64'h1 << (16*r)) : 64'h0);
            rd(16'(16'h0301 + 2*r), (r >= 4) ? (64'h1 << (16*(r-4))) : 64'h0);
        end
        idle(3);
        check("scoreboard_drained", expq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/tpu_ctrl.md
# tpu_ctrl

Host-side sequencer between the word-addressed host bus and the matrix datapath (memA, memB, systolic_array). It decodes host reads/writes into A-row loads, B-row shift-ins and C-row reads/writes. On a start command it runs the array for exactly 3*DIM-2 enabled cycles, then reports done. It owns every enable and write strobe into the datapath; the datapath never sees the host bus directly.

## Interface
- BITS_AB, 8, operand width
- BITS_C, 16, accumulator width
- DIM, 8, array dimension; DIM*BITS_AB must equal DATAW and DIM*BITS_C must equal 2*DATAW
- ADDRW, 16, host address width
- DATAW, 64, host data width
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  1  host request strobe, one access per cycle
- r_w  in  1  0=read, 1=write; valid with req
- addr  in  ADDRW  word address
- dataIn  in  DATAW  write data
- dataOut  out  DATAW  registered read data
- rd_valid  out  1  dataOut valid, one-cycle pulse
- a_en, a_wr_en  out  1  memA enable / row write
- a_row  out  clog2(DIM)  memA row select
- a_in  out  DATAW  memA row data
- b_en  out  1  memB shift enable
- b_in  out  DATAW  memB shift-in data
- sa_en, sa_wr_en  out  1  array compute enable / C row write
- c_row  out  clog2(DIM)  array C row select
- c_in  out  DIM*BITS_C  array C row write data
- c_out  in  DIM*BITS_C  array C row read data (combinational from c_row)

## Operation
- Region decode on addr[15:8]; r = addr[clog2(DIM)-1:0] for A, r = addr[clog2(DIM):1], h = addr[0] for C:
  - 0x01 A: write -> a_en=a_wr_en=1, a_row=r, a_in=dataIn same cycle. Read returns 0.
  - 0x02 B: write -> b_en=1, b_in=dataIn; low bits ignored, rows shift in write order. Read returns 0.
  - 0x03 C: read -> c_row=r, dataOut <= c_out half h (h=0 bits DATAW-1:0). Write h=0 -> hold <= dataIn, no strobe; write h=1 -> sa_wr_en=1, c_row=r, c_in={dataIn, hold}.
  - 0x04 CTRL: write bit0=1 -> start; bit1=1 -> clear done and err. Read -> {.., err[2], done[1], busy[0]}, zero-extended.
  - other regions: writes dropped, reads return 0.
- FSM IDLE -> RUN on accepted start; RUN -> IDLE when cycle counter reaches 3*DIM-2; done set on that transition.
- In RUN: a_en=b_en=sa_en=1 every cycle, b_in=0, a_wr_en=sa_wr_en=0.
- Any write during RUN (any region, including CTRL) is dropped and sets sticky err. Reads are served; C reads in RUN return in-progress values.
- Start while done=1 is legal; done clears on start.
- Start and clear in the same write: clear applied, then start.

## Timing
- Reset: IDLE, counter=0, busy=done=err=0, hold=0, dataOut=0, rd_valid=0, all strobes 0, a_row=c_row=0, a_in=b_in=c_in=0.
- Write strobes are combinational from req/r_w/addr in the request cycle (zero latency); rst forces all strobes 0.
- Read latency 1: req at cycle t -> dataOut and rd_valid=1 at t+1; dataOut holds until next read.
- Start at cycle t: busy=1 from t+1; sa_en high in cycles t+1..t+3*DIM-2 (22 cycles at DIM=8); busy=0, done=1 at t+3*DIM-1.
- Reset asserted in RUN: immediate return to IDLE on the next edge, enables low, done not set.

## Test plan
- Reset mid-RUN (cycle 10) -> sa_en low next cycle, status reads 0x0.
- Write 0x0100+3 with 0x0102..08 -> a_wr_en=1, a_row=3, a_in=0x0102..08 in that cycle only.
- Write C row 2: 0x0304 = 0xAAAA..., then 0x0305 = 0x5555... -> sa_wr_en only on second write, c_in={0x5555...,0xAAAA...}; read 0x0304 -> 0xAAAA... with rd_valid one cycle later.
- Write CTRL=0x1 -> sa_en high exactly 22 cycles (DIM=8), status 0x1 during, 0x2 after.
- Write 0x0100 during RUN -> no a_wr_en, status after run 0x6; write CTRL=0x2 -> status 0x0.
- Load identity A and B, start, read C -> each c_out row matches A*B with BITS_C accumulation.
